// File: rtl/serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder; the only arithmetic cell of the serial adder.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  logic w_p;

  assign w_p    = i_a ^ i_b;
  assign o_sum  = w_p ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & w_p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial a + b + cin, LSB first: one full adder, a carry flop and shift registers.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_start_ready;
  logic             r_done_valid;
  logic             w_s;
  logic             w_c;

  full_adder u_fa (
    .i_a    (r_a_sr[0]),
    .i_b    (r_b_sr[0]),
    .i_cin  (r_carry),
    .o_sum  (w_s),
    .o_cout (w_c)
  );

  // A transfer happens on a rising edge where valid and ready are both high;
  // valid may be raised at any time and ready never depends on valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_a_sr        <= '0;
      r_b_sr        <= '0;
      r_sum         <= '0;
      r_cnt         <= '0;
      r_carry       <= 1'b0;
      r_start_ready <= 1'b1;
      r_done_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid && r_start_ready) begin
            r_a_sr        <= a;
            r_b_sr        <= b;
            r_carry       <= cin;
            r_cnt         <= '0;
            r_start_ready <= 1'b0;
            r_state       <= RUN;
          end
        end
        RUN: begin
          // Each result bit enters at the MSB so bit 0 lands in sum[0] after WIDTH shifts.
          r_sum   <= {w_s, r_sum[WIDTH-1:1]};
          r_carry <= w_c;
          r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST_BIT) begin
            r_done_valid <= 1'b1;
            r_state      <= DONE;
          end
        end
        DONE: begin
          if (done_ready) begin
            r_done_valid  <= 1'b0;
            r_start_ready <= 1'b1;
            r_state       <= IDLE;
          end
        end
        default: begin
          r_done_valid  <= 1'b0;
          r_start_ready <= 1'b1;
          r_state       <= IDLE;
        end
      endcase
    end
  end

  assign start_ready = r_start_ready;
  assign done_valid  = r_done_valid;
  assign sum         = r_sum;
  assign cout        = r_carry;

endmodule
